// File: rtl/rl_ram_1rw_arbiter.sv
// Two-master arbiter in front of a single-port 1RW RAM with one-cycle read return.
// Define RL_RAM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module rl_ram_1rw_arbiter #(
   parameter  int ABITS = 10,
   parameter  int DBITS = 32,
   localparam int BBITS = (DBITS + 7) / 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             p0_req,
   output logic             p0_gnt,
   input  logic [ABITS-1:0] p0_addr,
   input  logic             p0_we,
   input  logic [BBITS-1:0] p0_be,
   input  logic [DBITS-1:0] p0_din,
   output logic             p0_rvalid,
   output logic [DBITS-1:0] p0_dout,
   input  logic             p1_req,
   output logic             p1_gnt,
   input  logic [ABITS-1:0] p1_addr,
   input  logic             p1_we,
   input  logic [BBITS-1:0] p1_be,
   input  logic [DBITS-1:0] p1_din,
   output logic             p1_rvalid,
   output logic [DBITS-1:0] p1_dout,
   output logic [ABITS-1:0] ram_addr,
   output logic             ram_we,
   output logic [BBITS-1:0] ram_be,
   output logic [DBITS-1:0] ram_din,
   input  logic [DBITS-1:0] ram_dout
);

   logic w_gnt0;
   logic w_gnt1;
   logic w_rd_xfer;
   logic r_rd_pend;
   logic r_rd_port;

`ifdef RL_RAM_ARB_FIXED_PRIO_EN
   assign w_gnt0 = p0_req;
   assign w_gnt1 = p1_req & ~p0_req;
`else
   // r_last holds the most recently granted port; the other one wins a tie.
   logic r_last;

   assign w_gnt0 = p0_req & (~p1_req | r_last);
   assign w_gnt1 = p1_req & (~p0_req | ~r_last);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_last <= 1'b1;
      end else if (w_gnt0) begin
         r_last <= 1'b0;
      end else if (w_gnt1) begin
         r_last <= 1'b1;
      end
   end
`endif

   assign p0_gnt = w_gnt0;
   assign p1_gnt = w_gnt1;

   // Idle cycles steer port 0 to the RAM so its inputs never float.
   assign ram_addr = w_gnt1 ? p1_addr : p0_addr;
   assign ram_be   = w_gnt1 ? p1_be   : p0_be;
   assign ram_din  = w_gnt1 ? p1_din  : p0_din;
   assign ram_we   = (w_gnt0 & p0_we) | (w_gnt1 & p1_we);

   assign w_rd_xfer = (w_gnt0 & ~p0_we) | (w_gnt1 & ~p1_we);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rd_pend <= 1'b0;
         r_rd_port <= 1'b0;
      end else begin
         r_rd_pend <= w_rd_xfer;
         if (w_rd_xfer) begin
            r_rd_port <= w_gnt1;
         end
      end
   end

   assign p0_rvalid = r_rd_pend & ~r_rd_port;
   assign p1_rvalid = r_rd_pend &  r_rd_port;
   assign p0_dout   = ram_dout;
   assign p1_dout   = ram_dout;

endmodule

// File: tb/tb_rl_ram_1rw_arbiter.sv
// Bench for rl_ram_1rw_arbiter: table-driven cycles, behavioural RAM, read-response scoreboard.
module tb_rl_ram_1rw_arbiter;

   localparam int AB = 10;
   localparam int DB = 32;
   localparam int BB = 4;
`ifdef RL_RAM_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rstn;
   logic          p0_req, p0_gnt, p0_we, p0_rvalid;
   logic [AB-1:0] p0_addr;
   logic [BB-1:0] p0_be;
   logic [DB-1:0] p0_din, p0_dout;
   logic          p1_req, p1_gnt, p1_we, p1_rvalid;
   logic [AB-1:0] p1_addr;
   logic [BB-1:0] p1_be;
   logic [DB-1:0] p1_din, p1_dout;
   logic [AB-1:0] ram_addr;
   logic          ram_we;
   logic [BB-1:0] ram_be;
   logic [DB-1:0] ram_din;
   logic [DB-1:0] ram_dout;

   always #5 clk = ~clk;

   rl_ram_1rw_arbiter #(.ABITS(AB), .DBITS(DB)) dut (
      .clk(clk), .rstn(rstn),
      .p0_req(p0_req), .p0_gnt(p0_gnt), .p0_addr(p0_addr), .p0_we(p0_we),
      .p0_be(p0_be), .p0_din(p0_din), .p0_rvalid(p0_rvalid), .p0_dout(p0_dout),
      .p1_req(p1_req), .p1_gnt(p1_gnt), .p1_addr(p1_addr), .p1_we(p1_we),
      .p1_be(p1_be), .p1_din(p1_din), .p1_rvalid(p1_rvalid), .p1_dout(p1_dout),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be), .ram_din(ram_din),
      .ram_dout(ram_dout)
   );

   // Single-port RAM: address sampled on the edge, data out the following cycle.
   logic [DB-1:0] mem [0:(1<<AB)-1];
   always @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < BB; i++) begin
            if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
         end
      end
      ram_dout <= mem[ram_addr];
   end

   typedef struct {
      logic          r0, w0;
      logic [AB-1:0] a0;
      logic [BB-1:0] b0;
      logic [DB-1:0] d0;
      logic          r1, w1;
      logic [AB-1:0] a1;
      logic [BB-1:0] b1;
      logic [DB-1:0] d1;
      logic          g0, g1;
   } vec_t;

   typedef struct {
      logic          port;
      logic [DB-1:0] data;
   } sb_t;

   sb_t           q[$];
   logic [DB-1:0] exp_mem [0:(1<<AB)-1];
   int            n_pass = 0;
   int            n_total = 0;
   vec_t          ph1 [14];
   vec_t          ph2 [6];

   function automatic vec_t mk(logic r0, logic w0, logic [AB-1:0] a0, logic [BB-1:0] b0,
                               logic [DB-1:0] d0, logic r1, logic w1, logic [AB-1:0] a1,
                               logic [BB-1:0] b1, logic [DB-1:0] d1, logic g0, logic g1);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.a0 = a0; v.b0 = b0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.b1 = b1; v.d1 = d1;
      v.g0 = g0; v.g1 = g1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic shadow_write(input logic [AB-1:0] a, input logic [BB-1:0] b,
                               input logic [DB-1:0] d);
      for (int i = 0; i < BB; i++) begin
         if (b[i]) exp_mem[a][8*i +: 8] = d[8*i +: 8];
      end
   endtask

   // Called #1 after a rising edge; checks mid-cycle and returns #1 after the next edge.
   task automatic apply(input vec_t v, input string name);
      sb_t e;
      p0_req = v.r0; p0_we = v.w0; p0_addr = v.a0; p0_be = v.b0; p0_din = v.d0;
      p1_req = v.r1; p1_we = v.w1; p1_addr = v.a1; p1_be = v.b1; p1_din = v.d1;
      #4;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk({name, "_p0_rvalid"}, p0_rvalid, e.port == 1'b0);
         chk({name, "_p1_rvalid"}, p1_rvalid, e.port == 1'b1);
         chk({name, "_dout"}, e.port ? p1_dout : p0_dout, e.data);
      end else begin
         chk({name, "_p0_rvalid"}, p0_rvalid, 1'b0);
         chk({name, "_p1_rvalid"}, p1_rvalid, 1'b0);
      end
      chk({name, "_p0_gnt"}, p0_gnt, v.g0);
      chk({name, "_p1_gnt"}, p1_gnt, v.g1);
      chk({name, "_ram_we"}, ram_we, (v.g0 & v.w0) | (v.g1 & v.w1));
      chk({name, "_ram_addr"}, ram_addr, v.g1 ? v.a1 : v.a0);
      if (v.g0) begin
         if (v.w0) shadow_write(v.a0, v.b0, v.d0);
         else begin e.port = 1'b0; e.data = exp_mem[v.a0]; q.push_back(e); end
      end
      if (v.g1) begin
         if (v.w1) shadow_write(v.a1, v.b1, v.d1);
         else begin e.port = 1'b1; e.data = exp_mem[v.a1]; q.push_back(e); end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      ph1[0]  = mk(0,0,10'h000,4'h0,32'h0,        0,0,10'h000,4'h0,32'h0,        0,0);
      ph1[1]  = mk(1,1,10'h010,4'hF,32'hDEADBEEF, 0,0,10'h000,4'h0,32'h0,        1,0);
      ph1[2]  = mk(1,0,10'h010,4'h0,32'h0,        0,0,10'h000,4'h0,32'h0,        1,0);
      ph1[3]  = mk(0,0,10'h000,4'h0,32'h0,        0,0,10'h000,4'h0,32'h0,        0,0);
      ph1[4]  = mk(0,0,10'h000,4'h0,32'h0,        1,1,10'h010,4'h3,32'h0000AAAA, 0,1);
      ph1[5]  = mk(0,0,10'h000,4'h0,32'h0,        1,0,10'h010,4'h0,32'h0,        0,1);
      ph1[6]  = mk(1,1,10'h001,4'hF,32'h11111111, 0,0,10'h000,4'h0,32'h0,        1,0);
      ph1[7]  = mk(0,0,10'h000,4'h0,32'h0,        1,1,10'h002,4'hF,32'h22222222, 0,1);
      ph1[8]  = mk(1,1,10'h003,4'hF,32'h33333333, 1,1,10'h004,4'hF,32'h44444444, 1,0);
      ph1[9]  = mk(1,1,10'h005,4'hF,32'h55555555, 1,1,10'h004,4'hF,32'h44444444, FIXED,!FIXED);
      ph1[10] = mk(0,0,10'h000,4'h0,32'h0,        1,1,10'h004,4'hF,32'h44444444, 0,1);
      ph1[11] = mk(1,0,10'h003,4'h0,32'h0,        0,0,10'h000,4'h0,32'h0,        1,0);
      ph1[12] = mk(0,0,10'h000,4'h0,32'h0,        1,0,10'h004,4'h0,32'h0,        0,1);
      ph1[13] = mk(1,0,10'h001,4'h0,32'h0,        0,0,10'h000,4'h0,32'h0,        1,0);

      ph2[0]  = mk(1,0,10'h001,4'h0,32'h0,        1,0,10'h002,4'h0,32'h0,        1,0);
      ph2[1]  = mk(1,0,10'h001,4'h0,32'h0,        1,0,10'h002,4'h0,32'h0,        1,0);
      ph2[2]  = mk(1,0,10'h001,4'h0,32'h0,        1,0,10'h002,4'h0,32'h0,        1,0);
      ph2[3]  = mk(1,0,10'h001,4'h0,32'h0,        1,0,10'h002,4'h0,32'h0,        1,0);
      ph2[4]  = mk(0,0,10'h000,4'h0,32'h0,        1,0,10'h002,4'h0,32'h0,        0,1);
      ph2[5]  = mk(0,0,10'h000,4'h0,32'h0,        0,0,10'h000,4'h0,32'h0,        0,0);
      if (!FIXED) begin
         ph2[1].g0 = 1'b0; ph2[1].g1 = 1'b1;
         ph2[3].g0 = 1'b0; ph2[3].g1 = 1'b1;
      end

      rstn = 1'b0;
      p0_req = 0; p0_we = 0; p0_addr = '0; p0_be = '0; p0_din = '0;
      p1_req = 0; p1_we = 0; p1_addr = '0; p1_be = '0; p1_din = '0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;

      for (int i = 0; i < 14; i++) apply(ph1[i], $sformatf("ph1_%0d", i));

      // The read transferred in ph1_13 must be dropped by the reset.
      p0_req = 0; p1_req = 0;
      rstn = 1'b0;
      q.delete();
      #1;
      chk("rst_mid_p0_rvalid", p0_rvalid, 1'b0);
      chk("rst_mid_ram_we", ram_we, 1'b0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;

      for (int i = 0; i < 6; i++) apply(ph2[i], $sformatf("ph2_%0d", i));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
